// File: rtl/spi_slave_apb_bridge_pkg.sv
// Shared definitions for the SPI-slave to APB bridge: command codes, field
// lengths, status bit positions, FSM encodings and the request payload.
package spi_slave_apb_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_STAT  = 8'h05;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 32;
  localparam int unsigned DUMMY_BITS = 8;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned STAT_BITS  = 8;
  localparam int unsigned CNT_W      = 6;

  localparam int unsigned STATUS_W   = 3;
  localparam int unsigned ST_SLVERR  = 0;
  localparam int unsigned ST_LATE    = 1;
  localparam int unsigned ST_OVERRUN = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    STAT,
    IGNORE
  } spi_state_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS
  } apb_state_e;

  // One APB request as handed from the SPI side to the APB master.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_req_t;

  // True when the counter sits on the last bit of a field of length len.
  function automatic logic last_bit(input logic [CNT_W-1:0] cnt, input int unsigned len);
    return cnt == CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/spi_slave_apb_bridge_apb.sv
// Generic single-outstanding APB master. A request pulse in A_IDLE starts a
// SETUP/ACCESS transfer; requests arriving while busy are dropped and flagged.
// Ports:
//   req_valid_i/req_i   request pulse and payload
//   rd_done_o           one-cycle pulse after a read completes (rdata_o valid)
//   err_o               one-cycle pulse when a transfer completed with pslverr
//   drop_o              one-cycle pulse when a request was refused (busy)
//   paddr..pslverr      APB master pins
module apb_master_fsm
  import spi_slave_apb_bridge_pkg::*;
#(
  parameter int unsigned P_ADDR_W = 32,
  parameter int unsigned P_DATA_W = 32
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                req_valid_i,
  input  apb_req_t            req_i,
  output logic                rd_done_o,
  output logic [P_DATA_W-1:0] rdata_o,
  output logic                err_o,
  output logic                drop_o,
  output logic [P_ADDR_W-1:0] paddr_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [P_DATA_W-1:0] pwdata_o,
  output logic [3:0]          pwstrb_o,
  input  logic                pready_i,
  input  logic [P_DATA_W-1:0] prdata_i,
  input  logic                pslverr_i
);

  apb_state_e          state_q, state_d;
  logic [P_ADDR_W-1:0] paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [P_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [3:0]          pwstrb_q, pwstrb_d;
  logic [P_DATA_W-1:0] rdata_q, rdata_d;
  logic                rd_done_q, rd_done_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;

  // State and registered APB outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= A_IDLE;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pwstrb_q  <= '0;
      rdata_q   <= '0;
      rd_done_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pwstrb_q  <= pwstrb_d;
      rdata_q   <= rdata_d;
      rd_done_q <= rd_done_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pwstrb_d  = pwstrb_q;
    rdata_d   = rdata_q;
    rd_done_d = 1'b0;
    err_d     = 1'b0;
    drop_d    = 1'b0;

    if (req_valid_i && (state_q != A_IDLE)) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      A_IDLE: begin
        if (req_valid_i) begin
          state_d  = A_SETUP;
          psel_d   = 1'b1;
          paddr_d  = P_ADDR_W'(req_i.addr);
          pwrite_d = req_i.write;
          pwdata_d = P_DATA_W'(req_i.wdata);
          pwstrb_d = req_i.strb;
        end
      end
      A_SETUP: begin
        state_d   = A_ACCESS;
        penable_d = 1'b1;
      end
      A_ACCESS: begin
        if (pready_i) begin
          state_d   = A_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_d     = pslverr_i;
          if (!pwrite_q) begin
            rdata_d   = prdata_i;
            rd_done_d = 1'b1;
          end
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  assign paddr_o   = paddr_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;
  assign pwstrb_o  = pwstrb_q;
  assign rdata_o   = rdata_q;
  assign rd_done_o = rd_done_q;
  assign err_o     = err_q;
  assign drop_o    = drop_q;

endmodule

// File: rtl/spi_slave_apb_bridge.sv
// SPI mode-0 responder that converts host byte commands into APB transfers.
// All logic runs on pclk; SCK/CS/MOSI are synchronized and edge-detected.
// Ports:
//   pclk, presetn                 APB clock, async active-low reset
//   spi_clk/spi_cs_n/spi_mosi     SPI pins from the host (oversampled)
//   spi_miso/spi_miso_oe          response data and its output enable
//   paddr..pslverr                APB master interface
//   status                        sticky {overrun, late, slverr}
module spi_slave_apb_bridge
  import spi_slave_apb_bridge_pkg::*;
#(
  parameter int unsigned P_ADDR_W    = 32,
  parameter int unsigned P_DATA_W    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                spi_clk,
  input  logic                spi_cs_n,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  output logic [P_ADDR_W-1:0] paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [P_DATA_W-1:0] pwdata,
  output logic [3:0]          pwstrb,
  input  logic                pready,
  input  logic [P_DATA_W-1:0] prdata,
  input  logic                pslverr,
  output logic [2:0]          status
);

  // Pin synchronizers plus one history flop for edge detection.
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_c = sck_s & ~sck_prev_q;
  assign sck_fall_c = ~sck_s & sck_prev_q;
  assign cs_rise_c  = cs_s & ~cs_prev_q;
  assign cs_fall_c  = ~cs_s & cs_prev_q;

  // APB side.
  apb_req_t                req_q, req_d;
  logic                    req_valid_q, req_valid_d;
  logic                    apb_rd_done, apb_err, apb_drop;
  logic [P_DATA_W-1:0]     apb_rdata;

  apb_master_fsm #(
    .P_ADDR_W (P_ADDR_W),
    .P_DATA_W (P_DATA_W)
  ) u_apb (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid_i (req_valid_q),
    .req_i       (req_q),
    .rd_done_o   (apb_rd_done),
    .rdata_o     (apb_rdata),
    .err_o       (apb_err),
    .drop_o      (apb_drop),
    .paddr_o     (paddr),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .pwstrb_o    (pwstrb),
    .pready_i    (pready),
    .prdata_i    (prdata),
    .pslverr_i   (pslverr)
  );

  // SPI protocol FSM registers.
  spi_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [30:0]            shin_q, shin_d;
  logic [31:0]            addr_q, addr_d;
  logic                   rd_cmd_q, rd_cmd_d;
  logic [31:0]            shout_q, shout_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;
  logic                   late_q, late_d;
  logic                   stat_clr_q, stat_clr_d;
  logic                   rd_valid_q;
  logic [STATUS_W-1:0]    status_q, status_d;
  logic [31:0]            bit_in_c;

  // Shift register contents including the bit arriving on this rise.
  assign bit_in_c = {shin_q, mosi_s};

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shin_q      <= '0;
      addr_q      <= '0;
      rd_cmd_q    <= 1'b0;
      shout_q     <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      late_q      <= 1'b0;
      stat_clr_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shin_q      <= shin_d;
      addr_q      <= addr_d;
      rd_cmd_q    <= rd_cmd_d;
      shout_q     <= shout_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      late_q      <= late_d;
      stat_clr_q  <= stat_clr_d;
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
      status_q    <= status_d;
    end
  end

  // Read data is valid only once the read issued by this frame has completed.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rd_valid_q <= 1'b0;
    end else if (req_valid_q && !req_q.write) begin
      rd_valid_q <= 1'b0;
    end else if (apb_rd_done) begin
      rd_valid_q <= 1'b1;
    end
  end

  // SPI next-state logic: cs edges dominate, then SCK rise/fall handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shin_d      = shin_q;
    addr_d      = addr_q;
    rd_cmd_d    = rd_cmd_q;
    shout_d     = shout_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    late_d      = 1'b0;
    stat_clr_d  = 1'b0;
    req_valid_d = 1'b0;
    req_d       = req_q;

    if (cs_rise_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      cnt_d   = '0;
    end else if (cs_fall_c) begin
      state_d = CMD;
      oe_d    = 1'b1;
      miso_d  = 1'b0;
      cnt_d   = '0;
    end else if (sck_rise_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        CMD: begin
          shin_d = bit_in_c[30:0];
          if (last_bit(cnt_q, CMD_BITS)) begin
            cnt_d = '0;
            unique case (bit_in_c[7:0])
              CMD_WRITE: begin state_d = ADDR; rd_cmd_d = 1'b0; end
              CMD_READ:  begin state_d = ADDR; rd_cmd_d = 1'b1; end
              CMD_STAT:  state_d = STAT;
              default:   state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          shin_d = bit_in_c[30:0];
          if (last_bit(cnt_q, ADDR_BITS)) begin
            cnt_d  = '0;
            addr_d = bit_in_c;
            if (rd_cmd_q) begin
              req_valid_d = 1'b1;
              req_d.write = 1'b0;
              req_d.addr  = bit_in_c;
              req_d.wdata = '0;
              req_d.strb  = 4'h0;
              state_d     = DUMMY;
            end else begin
              state_d = WDATA;
            end
          end
        end
        WDATA: begin
          shin_d = bit_in_c[30:0];
          if (last_bit(cnt_q, DATA_BITS)) begin
            req_valid_d = 1'b1;
            req_d.write = 1'b1;
            req_d.addr  = addr_q;
            req_d.wdata = bit_in_c;
            req_d.strb  = 4'hF;
            state_d     = IGNORE;
          end
        end
        DUMMY: begin
          // Hold at the full count until the following fall loads read data.
          if (cnt_q == CNT_W'(DUMMY_BITS)) cnt_d = cnt_q;
        end
        RDATA: begin
          if (last_bit(cnt_q, DATA_BITS)) state_d = IGNORE;
        end
        STAT: begin
          if (last_bit(cnt_q, STAT_BITS)) begin
            stat_clr_d = 1'b1;
            state_d    = IGNORE;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end else if (sck_fall_c) begin
      unique case (state_q)
        DUMMY: begin
          if (cnt_q == CNT_W'(DUMMY_BITS)) begin
            if (rd_valid_q) begin
              shout_d = 32'(apb_rdata);
            end else begin
              shout_d = '0;
              late_d  = 1'b1;
            end
            miso_d  = shout_d[31];
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        RDATA: begin
          miso_d  = shout_q[30];
          shout_d = {shout_q[30:0], 1'b0};
        end
        STAT: begin
          // First fall after the command byte loads the snapshot.
          if (cnt_q == '0) begin
            shout_d = {5'b0, status_q, 24'b0};
            miso_d  = 1'b0;
          end else begin
            miso_d  = shout_q[30];
            shout_d = {shout_q[30:0], 1'b0};
          end
        end
        IGNORE:  miso_d = 1'b0;
        default: miso_d = miso_q;
      endcase
    end
  end

  // Sticky status: a clear and a new flag in the same cycle keep the flag.
  always_comb begin
    status_d = stat_clr_q ? '0 : status_q;
    if (apb_err)  status_d[ST_SLVERR]  = 1'b1;
    if (late_q)   status_d[ST_LATE]    = 1'b1;
    if (apb_drop) status_d[ST_OVERRUN] = 1'b1;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign status      = status_q;

endmodule

// File: tb/tb_spi_slave_apb_bridge.sv
// Bench for spi_slave_apb_bridge: SPI host tasks, an APB slave responder that
// logs completed transfers, directed scenarios and a randomized phase checked
// against a transaction-level model of the bridge.
module tb_spi_slave_apb_bridge;

  localparam int HALF = 80;

  logic        pclk;
  logic        presetn;
  logic        spi_clk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [2:0]  status;

  spi_slave_apb_bridge dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pwstrb      (pwstrb),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr),
    .status      (status)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // APB slave responder and transfer log.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
    logic [3:0]  strb;
  } txn_t;

  txn_t        log_q[$];
  int          psel_cycles;
  int          cfg_wait;
  logic [31:0] cfg_rdata;
  logic        cfg_err;

  initial begin : apb_slave
    int   wcnt;
    txn_t t;
    wcnt        = 0;
    psel_cycles = 0;
    pready      = 1'b0;
    prdata      = '0;
    pslverr     = 1'b0;
    forever begin
      @(negedge pclk);
      if (psel) psel_cycles++;
      if (psel && penable && !pready) begin
        if (wcnt >= cfg_wait) begin
          pready  = 1'b1;
          prdata  = cfg_rdata;
          pslverr = cfg_err;
          t.addr  = paddr;
          t.data  = pwdata;
          t.write = pwrite;
          t.strb  = pwstrb;
          log_q.push_back(t);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
      end
    end
  end

  // SPI host (mode 0): MOSI set while SCK low, MISO sampled on SCK rise.
  task automatic spi_start();
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      #(HALF);
      spi_clk = 1'b1;
      rx = {rx[30:0], spi_miso};
      #(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_end();
    spi_mosi = 1'b0;
    #(HALF);
    spi_cs_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rx;
    spi_start();
    spi_bits(32'h02, 8, rx);
    spi_bits(a, 32, rx);
    spi_bits(d, 32, rx);
    spi_end();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data);
    logic [31:0] rx;
    spi_start();
    spi_bits(32'h03, 8, rx);
    spi_bits(a, 32, rx);
    spi_bits(32'h0, 8, rx);
    spi_bits(32'h0, 32, data);
    spi_end();
  endtask

  task automatic do_stat(output logic [31:0] data);
    logic [31:0] rx;
    spi_start();
    spi_bits(32'h05, 8, rx);
    spi_bits(32'h0, 8, data);
    spi_end();
  endtask

  task automatic wait_apb_idle(input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge pclk);
    while (psel && n < budget) begin
      @(negedge pclk);
      n++;
    end
    chk("apb_idle", 32'(psel), 32'h0);
  endtask

  initial begin : watchdog
    #(3ms);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rx, rx2;
  int          n0, p0;
  logic [2:0]  exp_status;
  txn_t        t;

  initial begin : main
    cfg_wait  = 0;
    cfg_rdata = '0;
    cfg_err   = 1'b0;
    presetn   = 1'b0;
    spi_clk   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_mosi  = 1'b0;
    repeat (5) @(negedge pclk);

    chk("rst_psel",    32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_pwrite",  32'(pwrite), 32'h0);
    chk("rst_paddr",   paddr, 32'h0);
    chk("rst_pwdata",  pwdata, 32'h0);
    chk("rst_pwstrb",  32'(pwstrb), 32'h0);
    chk("rst_status",  32'(status), 32'h0);
    chk("rst_miso",    32'(spi_miso), 32'h0);
    chk("rst_oe",      32'(spi_miso_oe), 32'h0);

    presetn = 1'b1;
    repeat (5) @(negedge pclk);

    // Basic write, with output-enable checked across the frame.
    n0 = log_q.size();
    p0 = psel_cycles;
    spi_start();
    chk("oe_in_frame", 32'(spi_miso_oe), 32'h1);
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h1000_0004, 32, rx);
    spi_bits(32'hA5A5_1234, 32, rx);
    spi_end();
    chk("oe_after_frame", 32'(spi_miso_oe), 32'h0);
    wait_apb_idle(100);
    chk("wr_count", 32'(log_q.size() - n0), 32'h1);
    t = log_q[n0];
    chk("wr_addr",  t.addr, 32'h1000_0004);
    chk("wr_data",  t.data, 32'hA5A5_1234);
    chk("wr_dir",   32'(t.write), 32'h1);
    chk("wr_strb",  32'(t.strb), 32'hF);
    chk("wr_psel_cycles", 32'(psel_cycles - p0), 32'h2);

    // Read with three wait states.
    cfg_wait  = 3;
    cfg_rdata = 32'hCAFE_F00D;
    n0 = log_q.size();
    do_read(32'h1000_0008, rx);
    wait_apb_idle(100);
    chk("rd_data", rx, 32'hCAFE_F00D);
    chk("rd_addr", log_q[n0].addr, 32'h1000_0008);
    chk("rd_dir",  32'(log_q[n0].write), 32'h0);
    chk("rd_status", 32'(status), 32'h0);

    // Read whose slave stalls past the dummy byte.
    cfg_wait  = 200;
    cfg_rdata = 32'h1234_5678;
    do_read(32'h2000_0000, rx);
    wait_apb_idle(1000);
    chk("late_data", rx, 32'h0);
    cfg_wait = 0;
    do_stat(rx);
    chk("late_stat1", rx, 32'h02);
    do_stat(rx);
    chk("late_stat2", rx, 32'h00);

    // Write answered with pslverr.
    cfg_err = 1'b1;
    do_write(32'h3000_0000, 32'h0000_0001);
    wait_apb_idle(100);
    cfg_err = 1'b0;
    do_stat(rx);
    chk("slverr_stat", rx, 32'h01);

    // Frame aborted mid-address, then a clean write.
    n0 = log_q.size();
    p0 = psel_cycles;
    spi_start();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h0004_5678, 20, rx);
    spi_end();
    repeat (20) @(negedge pclk);
    chk("abort_psel", 32'(psel_cycles - p0), 32'h0);
    chk("abort_log",  32'(log_q.size() - n0), 32'h0);
    do_write(32'h4000_0010, 32'hDEAD_BEEF);
    wait_apb_idle(100);
    chk("post_abort_count", 32'(log_q.size() - n0), 32'h1);
    chk("post_abort_addr",  log_q[n0].addr, 32'h4000_0010);
    chk("post_abort_data",  log_q[n0].data, 32'hDEAD_BEEF);

    // Unknown command.
    n0 = log_q.size();
    spi_start();
    spi_bits(32'h7E, 8, rx);
    spi_bits(32'hFFFF_FFFF, 32, rx2);
    spi_end();
    repeat (10) @(negedge pclk);
    chk("badcmd_miso_cmd",  rx, 32'h0);
    chk("badcmd_miso_tail", rx2, 32'h0);
    chk("badcmd_log", 32'(log_q.size() - n0), 32'h0);

    // Second write while the slave is stalled gets dropped.
    n0 = log_q.size();
    cfg_wait = 32'h7FFF_FFFF;
    do_write(32'h5000_0000, 32'h1111_1111);
    do_write(32'h6000_0000, 32'h2222_2222);
    chk("ovr_status_port", 32'(status), 32'h4);
    cfg_wait = 0;
    wait_apb_idle(100);
    chk("ovr_count", 32'(log_q.size() - n0), 32'h1);
    chk("ovr_addr",  log_q[n0].addr, 32'h5000_0000);
    do_stat(rx);
    chk("ovr_stat", rx, 32'h04);

    // Randomized phase against a transaction-level model.
    exp_status = 3'b000;
    for (int k = 0; k < 16; k++) begin
      int          op;
      logic [31:0] a, d;
      logic [7:0]  c;
      op        = $urandom_range(0, 3);
      a         = $urandom;
      d         = $urandom;
      cfg_wait  = $urandom_range(0, 5);
      cfg_err   = ($urandom_range(0, 3) == 0);
      cfg_rdata = $urandom;
      n0        = log_q.size();
      case (op)
        0: begin
          do_write(a, d);
          wait_apb_idle(100);
          chk("rnd_wr_count", 32'(log_q.size() - n0), 32'h1);
          chk("rnd_wr_addr", log_q[n0].addr, a);
          chk("rnd_wr_data", log_q[n0].data, d);
          chk("rnd_wr_strb", 32'(log_q[n0].strb), 32'hF);
          if (cfg_err) exp_status[0] = 1'b1;
        end
        1: begin
          do_read(a, rx);
          wait_apb_idle(100);
          chk("rnd_rd_count", 32'(log_q.size() - n0), 32'h1);
          chk("rnd_rd_addr", log_q[n0].addr, a);
          chk("rnd_rd_dir",  32'(log_q[n0].write), 32'h0);
          chk("rnd_rd_data", rx, cfg_rdata);
          if (cfg_err) exp_status[0] = 1'b1;
        end
        2: begin
          do_stat(rx);
          chk("rnd_stat", rx, 32'({5'b0, exp_status}));
          exp_status = 3'b000;
        end
        default: begin
          do begin
            c = 8'($urandom);
          end while (c == 8'h02 || c == 8'h03 || c == 8'h05);
          spi_start();
          spi_bits(32'(c), 8, rx);
          spi_bits(a, 32, rx2);
          spi_end();
          repeat (10) @(negedge pclk);
          chk("rnd_bad_miso", rx2, 32'h0);
          chk("rnd_bad_log", 32'(log_q.size() - n0), 32'h0);
        end
      endcase
      chk("rnd_status_port", 32'(status), 32'(exp_status));
    end
    cfg_err = 1'b0;
    do_stat(rx);
    chk("final_stat", rx, 32'({5'b0, exp_status}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
